// File: rtl/branch_seq.sv
// ---------------------------------------------------------------------------
// branch_seq
//
// Control sequencer for one instruction-fetch plus conditional-branch
// sequence. It walks T0..T6 and raises the datapath control strobes for each
// step. The condition is evaluated against Ra in T3 and latched into the CON
// flip-flop. In T6 that flop decides whether the branch target is loaded
// into the PC.
//
// Optional feature (macro BR_LINK_EN):
//   When defined, cond 110 becomes branch-and-link (always taken). An extra
//   step T4L between T3 and T4 writes the return PC into R15. This also adds
//   the ports o_link_out and o_rin.
//
// Parameters
//   DATA_W    width of the Ra operand
//   MAX_WAIT  T1 cycles without mem_ready before the fetch is aborted (1..255)
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_clr        synchronous active-high reset, highest priority
//   i_start      request a sequence (only looked at while idle)
//   i_cond       branch condition: 000 zr, 001 nz, 010 pl, 011 mi,
//                100 always, 101 never, 11x reserved
//   i_ra_val     Ra value on the bus, sampled in T3
//   i_mem_ready  memory read data valid during T1
//   o_pc_out .. o_c_out   datapath control strobes
//   o_con_flag   CON flip-flop
//   o_busy       high whenever not idle
//   o_done       one-cycle pulse during T6
//   o_err        sticky timeout / reserved-condition flag
//   o_state      current state encoding, for debug
//   o_link_out, o_rin     (BR_LINK_EN only) link-path strobes
// ---------------------------------------------------------------------------
module branch_seq #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic [2:0]        i_cond,
    input  logic [DATA_W-1:0] i_ra_val,
    input  logic              i_mem_ready,
    output logic              o_pc_out,
    output logic              o_mar_in,
    output logic              o_zlo_in,
    output logic              o_zlo_out,
    output logic              o_pc_in,
    output logic              o_inc_pc,
    output logic              o_read,
    output logic              o_mdr_in,
    output logic              o_mdr_out,
    output logic              o_ir_in,
    output logic              o_gra,
    output logic              o_r_out,
    output logic              o_con_in,
    output logic              o_y_in,
    output logic              o_c_out,
    output logic              o_con_flag,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [3:0]        o_state
`ifdef BR_LINK_EN
    ,
    output logic              o_link_out,
    output logic              o_rin
`endif
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T4L  = 4'd8
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_waitCnt;
    logic       r_conFlag;
    logic       r_err;

    logic       w_conVal;
    logic       w_condReserved;
    logic       w_isLink;
    logic       w_timeout;
    logic       w_accept;

    // Condition evaluation against the Ra operand. A reserved code yields a
    // not-taken result so the PC is left alone while err gets flagged.
    always_comb begin
        w_conVal       = 1'b0;
        w_condReserved = 1'b0;
        w_isLink       = 1'b0;
        case (i_cond)
            3'b000:  w_conVal = (i_ra_val == '0);
            3'b001:  w_conVal = (i_ra_val != '0);
            3'b010:  w_conVal = ~i_ra_val[DATA_W-1];
            3'b011:  w_conVal = i_ra_val[DATA_W-1];
            3'b100:  w_conVal = 1'b1;
            3'b101:  w_conVal = 1'b0;
`ifdef BR_LINK_EN
            3'b110: begin
                w_conVal = 1'b1;
                w_isLink = 1'b1;
            end
`endif
            default: w_condReserved = 1'b1;
        endcase
    end

    // The wait counter holds the number of not-ready T1 cycles already
    // spent. The abort fires on the cycle that would bring it to MAX_WAIT.
    // A ready memory in that same cycle still wins.
    assign w_timeout = (r_state == S_T1) && !i_mem_ready
                       && ((r_waitCnt + 8'd1) == LP_MAX_WAIT);
    assign w_accept  = (r_state == S_IDLE) && i_start;

    // Next-state logic. T1 is the only step that can stretch.
    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:  w_nextState = i_start ? S_T0 : S_IDLE;
            S_T0:    w_nextState = S_T1;
            S_T1: begin
                if (i_mem_ready)
                    w_nextState = S_T2;
                else if (w_timeout)
                    w_nextState = S_IDLE;
                else
                    w_nextState = S_T1;
            end
            S_T2:    w_nextState = S_T3;
            S_T3:    w_nextState = w_isLink ? S_T4L : S_T4;
            S_T4L:   w_nextState = S_T4;
            S_T4:    w_nextState = S_T5;
            S_T5:    w_nextState = S_T6;
            S_T6:    w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // State, wait counter, CON flop and sticky error. clr overrides
    // everything, including a start or mem_ready seen in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 8'd0;
            r_conFlag <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == S_T1) && !i_mem_ready && !w_timeout)
                r_waitCnt <= r_waitCnt + 8'd1;
            else
                r_waitCnt <= 8'd0;
            if (r_state == S_T3)
                r_conFlag <= w_conVal;
            if (w_accept)
                r_err <= 1'b0;
            else if (w_timeout || ((r_state == S_T3) && w_condReserved))
                r_err <= 1'b1;
        end
    end

    // Strobe decode from registered state only. r_waitCnt is zero exactly
    // in the first T1 cycle, which limits the PC increment write-back to once.
    always_comb begin
        o_pc_out  = 1'b0;
        o_mar_in  = 1'b0;
        o_zlo_in  = 1'b0;
        o_zlo_out = 1'b0;
        o_pc_in   = 1'b0;
        o_inc_pc  = 1'b0;
        o_read    = 1'b0;
        o_mdr_in  = 1'b0;
        o_mdr_out = 1'b0;
        o_ir_in   = 1'b0;
        o_gra     = 1'b0;
        o_r_out   = 1'b0;
        o_con_in  = 1'b0;
        o_y_in    = 1'b0;
        o_c_out   = 1'b0;
        o_done    = 1'b0;
`ifdef BR_LINK_EN
        o_link_out = 1'b0;
        o_rin      = 1'b0;
`endif
        case (r_state)
            S_T0: begin
                o_pc_out = 1'b1;
                o_mar_in = 1'b1;
                o_zlo_in = 1'b1;
                o_inc_pc = 1'b1;
            end
            S_T1: begin
                o_read    = 1'b1;
                o_mdr_in  = 1'b1;
                o_zlo_out = (r_waitCnt == 8'd0);
                o_pc_in   = (r_waitCnt == 8'd0);
            end
            S_T2: begin
                o_mdr_out = 1'b1;
                o_ir_in   = 1'b1;
            end
            S_T3: begin
                o_gra    = 1'b1;
                o_r_out  = 1'b1;
                o_con_in = 1'b1;
            end
`ifdef BR_LINK_EN
            // The return address travels over the bus through pc_out.
            // link_out is kept low so that only one bus driver is active.
            S_T4L: begin
                o_pc_out = 1'b1;
                o_rin    = 1'b1;
            end
`endif
            S_T4: begin
                o_pc_out = 1'b1;
                o_y_in   = 1'b1;
            end
            S_T5: begin
                o_c_out  = 1'b1;
                o_zlo_in = 1'b1;
            end
            S_T6: begin
                o_zlo_out = 1'b1;
                o_pc_in   = r_conFlag;
                o_done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_con_flag = r_conFlag;
    assign o_err      = r_err;
    assign o_busy     = (r_state != S_IDLE);
    assign o_state    = r_state;

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter DATA_W, default 32, width of condition operand ra_val.
REQ-002 Parameter MAX_WAIT, default 15, maximum T1 cycles spent waiting on mem_ready before abort; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one fetch+conditional-branch sequence; sampled only in IDLE.
REQ-006 cond  input  3  branch condition from IR C2 field: 000 zr, 001 nz, 010 pl, 011 mi, 100 always, 101 never, 11x reserved.
REQ-007 ra_val  input  DATA_W  Ra value on bus, sampled in T3.
REQ-008 mem_ready  input  1  memory read data valid during T1.
REQ-009 pc_out, mar_in, zlo_in, zlo_out, pc_in, inc_pc, read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out  output  1 each  datapath control strobes.
REQ-010 con_flag  output  1  registered CON flip-flop value.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 done  output  1  one-cycle pulse on completion of T6.
REQ-013 err  output  1  sticky: memory timeout or reserved cond; cleared by clr or accepted start.
REQ-014 state  output  4  current state encoding for debug.

Function
REQ-015 States IDLE, T0, T1, T2, T3, T4, T5, T6; every non-IDLE state lasts one cycle except T1.
REQ-016 IDLE -> T0 on start=1; start while busy is ignored, not queued.
REQ-017 T0 asserts pc_out, mar_in, zlo_in, inc_pc.
REQ-018 T1 asserts zlo_out, pc_in, read, mdr_in; advances to T2 on the edge where mem_ready=1; zlo_out/pc_in assert only in the first T1 cycle.
REQ-019 T1 wait counter counts cycles with mem_ready=0; reaching MAX_WAIT -> err=1, return to IDLE, no done.
REQ-020 T2 asserts mdr_out, ir_in.
REQ-021 T3 asserts gra, r_out, con_in; con_flag loads at end of T3: zr ra_val==0; nz ra_val!=0; pl ra_val[DATA_W-1]==0; mi ra_val[DATA_W-1]==1; always 1; never 0.
REQ-022 Reserved cond in T3: con_flag=0, err=1, sequence continues, PC unchanged.
REQ-023 T4 asserts pc_out, y_in; T5 asserts c_out, zlo_in.
REQ-024 T6 asserts zlo_out, and pc_in equal to con_flag; done=1 for the same cycle; next state IDLE.
REQ-025 All strobes outputs of registered state decode, glitch-free; at most one bus driver (pc_out, zlo_out, mdr_out, r_out, c_out, link_out) high per cycle.
REQ-026 con_flag holds its value until the next T3 or clr.
REQ-027 start=1 in the same cycle as done: start is accepted one cycle later (IDLE first).

Reset
REQ-028 clr=1 at a rising edge: state=IDLE, all strobes 0, con_flag=0, busy=0, done=0, err=0, wait counter=0, regardless of current state.
REQ-029 clr mid-sequence aborts with no done and no pc_in in the following cycle.
REQ-030 clr has priority over start and mem_ready.

Configuration
REQ-031 Macro BR_LINK_EN compiled in: extra output link_out (1) and rin (1); for cond 110 (branch-and-link, always taken) an extra state T4L between T3 and T4 asserts pc_out and rin to write return PC to R15; 110 not reserved.
REQ-032 Without BR_LINK_EN: no link_out/rin ports, no T4L, cond 11x reserved per REQ-022.

Verification
REQ-033 cond=000, ra_val=0, mem_ready=1 in first T1 -> con_flag=1, pc_in=1 in T6, done 7 cycles after start edge.
REQ-034 cond=011, ra_val=0x7FFFFFFF -> con_flag=0, pc_in=0 in T6, done still pulses.
REQ-035 mem_ready held 0, MAX_WAIT=3 -> err=1 after 3 T1 cycles, IDLE, no done, busy=0.
REQ-036 clr asserted in T4 -> next cycle IDLE, all strobes 0, con_flag=0.
REQ-037 cond=111 without BR_LINK_EN -> err=1, con_flag=0, pc_in=0 in T6; with BR_LINK_EN cond=110 -> rin=1 in T4L, pc_in=1 in T6.
REQ-038 start held high continuously -> back-to-back sequences separated by exactly one IDLE cycle; driver-exclusivity assertion never fails.
